// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - mdu op codes, FSM state encoding and op decode shared with the ALU decoder
package mdu_pkg;

    localparam logic [4:0] OP_MUL   = 5'd2;
    localparam logic [4:0] OP_DIV   = 5'd3;
    localparam logic [4:0] OP_DIVU  = 5'd4;
    localparam logic [4:0] OP_REM   = 5'd5;
    localparam logic [4:0] OP_REMU  = 5'd6;
    localparam logic [4:0] OP_MULW  = 5'd24;
    localparam logic [4:0] OP_DIVW  = 5'd25;
    localparam logic [4:0] OP_DIVUW = 5'd26;
    localparam logic [4:0] OP_REMW  = 5'd27;
    localparam logic [4:0] OP_REMUW = 5'd28;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    typedef enum logic [1:0] {
        K_NONE = 2'd0,
        K_MUL  = 2'd1,
        K_DIV  = 2'd2,
        K_REM  = 2'd3
    } mdu_kind_e;

    typedef struct packed {
        mdu_kind_e kind;
        logic      w;
        logic      sgn;
    } mdu_dec_t;

    function automatic mdu_dec_t mdu_decode(input logic [4:0] op);
        mdu_dec_t d;
        d.kind = K_NONE;
        d.w    = 1'b0;
        d.sgn  = 1'b0;
        case (op)
            OP_MUL:   d.kind = K_MUL;
            OP_DIV:   begin d.kind = K_DIV; d.sgn = 1'b1; end
            OP_DIVU:  d.kind = K_DIV;
            OP_REM:   begin d.kind = K_REM; d.sgn = 1'b1; end
            OP_REMU:  d.kind = K_REM;
            OP_MULW:  begin d.kind = K_MUL; d.w = 1'b1; end
            OP_DIVW:  begin d.kind = K_DIV; d.w = 1'b1; d.sgn = 1'b1; end
            OP_DIVUW: begin d.kind = K_DIV; d.w = 1'b1; end
            OP_REMW:  begin d.kind = K_REM; d.w = 1'b1; d.sgn = 1'b1; end
            OP_REMUW: begin d.kind = K_REM; d.w = 1'b1; end
            default:  d.kind = K_NONE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one restoring division step: shift in a dividend bit, trial-subtract the divisor
module mdu_div_step #(
    parameter int N = 64
) (
    input  logic [N-1:0] i_rem,
    input  logic [N-1:0] i_div,
    input  logic         i_bit,
    output logic [N-1:0] o_rem,
    output logic         o_q
);

    logic [N:0] w_shift;
    logic [N:0] w_diff;

    // i_rem < i_div always holds, so a set top bit of the difference means the trial borrowed
    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {1'b0, i_div};
    assign o_q     = ~w_diff[N];
    assign o_rem   = o_q ? w_diff[N-1:0] : w_shift[N-1:0];

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - iterative multiply/divide controller; define MDU_FAST_MUL_EN for a single-cycle multiplier
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] res,
    input  logic         flush,
    output logic         busy
);

    localparam int CW = $clog2(N + 1);

    function automatic logic [N-1:0] sext32(input logic [31:0] v);
        return {{(N-32){v[31]}}, v};
    endfunction

    mdu_state_e     r_state;
    mdu_state_e     w_state_nxt;
    mdu_kind_e      r_kind;
    logic           r_w;
    logic           r_neg_q;
    logic           r_neg_r;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_x;
    logic [N-1:0]   r_y;
    logic [N-1:0]   r_acc;
    logic [N-1:0]   r_res;

    mdu_dec_t       w_dec;
    logic [N-1:0]   w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_min, w_prod;
    logic           w_a_neg, w_b_neg, w_b_zero, w_ovf, w_fast_mul;
    logic           w_direct, w_accept, w_last;
    logic [N-1:0]   w_direct_raw, w_direct_res;
    logic [N-1:0]   w_x_nxt, w_y_nxt, w_acc_nxt, w_step_raw, w_step_res;
    logic [N-1:0]   w_ds_rem;
    logic           w_ds_q;

    assign w_dec    = mdu_decode(op);
    assign w_a_ext  = w_dec.w ? (w_dec.sgn ? sext32(a[31:0]) : {{(N-32){1'b0}}, a[31:0]}) : a;
    assign w_b_ext  = w_dec.w ? (w_dec.sgn ? sext32(b[31:0]) : {{(N-32){1'b0}}, b[31:0]}) : b;
    assign w_a_neg  = w_dec.sgn & w_a_ext[N-1];
    assign w_b_neg  = w_dec.sgn & w_b_ext[N-1];
    assign w_a_mag  = w_a_neg ? ('0 - w_a_ext) : w_a_ext;
    assign w_b_mag  = w_b_neg ? ('0 - w_b_ext) : w_b_ext;
    assign w_min    = w_dec.w ? {{(N-31){1'b1}}, 31'd0} : {1'b1, {(N-1){1'b0}}};
    assign w_b_zero = (w_b_ext == '0);
    assign w_ovf    = w_dec.sgn && (w_a_ext == w_min) && (&w_b_ext);

`ifdef MDU_FAST_MUL_EN
    assign w_fast_mul = (w_dec.kind == K_MUL);
    assign w_prod     = w_a_ext * w_b_ext;
`else
    assign w_fast_mul = 1'b0;
    assign w_prod     = '0;
`endif

    assign in_ready  = (r_state == ST_IDLE) && !flush;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_cnt == CW'(1));
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign res       = r_res;

    // Cases resolved on the acceptance edge: unknown op, zero divisor, signed overflow, fast multiply
    always_comb begin
        w_direct     = 1'b0;
        w_direct_raw = '0;
        case (w_dec.kind)
            K_MUL: begin
                w_direct     = w_fast_mul;
                w_direct_raw = w_prod;
            end
            K_DIV: begin
                w_direct     = w_b_zero | w_ovf;
                w_direct_raw = w_b_zero ? '1 : w_a_ext;
            end
            K_REM: begin
                w_direct     = w_b_zero | w_ovf;
                w_direct_raw = w_b_zero ? w_a_ext : '0;
            end
            default: w_direct = 1'b1;
        endcase
    end

    assign w_direct_res = w_dec.w ? sext32(w_direct_raw[31:0]) : w_direct_raw;

    mdu_div_step #(.N(N)) u_div_step (
        .i_rem (r_acc),
        .i_div (r_y),
        .i_bit (r_x[N-1]),
        .o_rem (w_ds_rem),
        .o_q   (w_ds_q)
    );

    // r_x: multiplicand or dividend/quotient shift register; r_y: multiplier or divisor; r_acc: product or remainder
    always_comb begin
        w_x_nxt    = r_x;
        w_y_nxt    = r_y;
        w_acc_nxt  = r_acc;
        w_step_raw = '0;
        if (r_kind == K_MUL) begin
            w_acc_nxt = r_acc + (r_y[0] ? r_x : '0);
            w_x_nxt   = r_x << 1;
            w_y_nxt   = r_y >> 1;
        end else begin
            w_acc_nxt = w_ds_rem;
            w_x_nxt   = {r_x[N-2:0], w_ds_q};
        end
        case (r_kind)
            K_MUL:   w_step_raw = w_acc_nxt;
            K_DIV:   w_step_raw = r_neg_q ? ('0 - w_x_nxt) : w_x_nxt;
            K_REM:   w_step_raw = r_neg_r ? ('0 - w_acc_nxt) : w_acc_nxt;
            default: w_step_raw = '0;
        endcase
    end

    assign w_step_res = r_w ? sext32(w_step_raw[31:0]) : w_step_raw;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = w_direct ? ST_DONE : ST_CALC;
            ST_CALC: if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (flush) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kind  <= K_NONE;
            r_w     <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_cnt   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_acc   <= '0;
            r_res   <= '0;
        end else if (w_accept) begin
            r_kind  <= w_dec.kind;
            r_w     <= w_dec.w;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_cnt   <= w_dec.w ? CW'(32) : CW'(N);
            r_acc   <= '0;
            if (w_dec.kind == K_MUL) begin
                r_x <= w_a_ext;
                r_y <= w_b_ext;
            end else begin
                // W dividends start in the upper half so the step always consumes bit N-1
                r_x <= w_dec.w ? (w_a_mag << 32) : w_a_mag;
                r_y <= w_b_mag;
            end
            if (w_direct) r_res <= w_direct_res;
        end else if (r_state == ST_CALC && !flush) begin
            r_x   <= w_x_nxt;
            r_y   <= w_y_nxt;
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt - CW'(1);
            if (w_last) r_res <= w_step_res;
        end
    end

endmodule
